// File: rtl/mem_access_ctrl_if.sv
// CPU request/response and word-memory signals of the memory access controller.
// master = CPU plus memory side of the bench, slave = the controller.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_memRead;
  logic        mem_memWrite;
  logic [31:0] mem_memData;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_memData,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_address, mem_writeData, mem_memRead, mem_memWrite
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_memData,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_address, mem_writeData, mem_memRead, mem_memWrite
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory initiator: byte-address CPU requests -> word-indexed strobes; latency read READ_WAIT+1, write 2, error 1.
// req_ready is low from the accept edge until the one-cycle response pulse has ended.
module mem_access_ctrl #(
  parameter int DEPTH     = 256,
  parameter int READ_WAIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [3:0]  CNT_INIT  = 4'(READ_WAIT - 1);
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
  localparam logic [31:0] IDLE_DATA = 32'h0000_0000;

  state_t      state_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_writeData_q;
  logic        mem_memRead_q;
  logic        mem_memWrite_q;
  logic [3:0]  cnt_q;

  logic [3:0]  cnt_d;
  logic [31:0] word_idx;
  logic        addr_err;
  logic        accept;

  assign word_idx = {2'b00, bus.req_addr[31:2]};
  assign addr_err = (bus.req_addr[1:0] != 2'b00) || (word_idx >= DEPTH_W);
  assign accept   = bus.req_valid && req_ready_q;
  assign cnt_d    = cnt_q - 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_err_q      <= 1'b0;
      resp_rdata_q    <= IDLE_DATA;
      mem_address_q   <= IDLE_DATA;
      mem_writeData_q <= IDLE_DATA;
      mem_memRead_q   <= 1'b0;
      mem_memWrite_q  <= 1'b0;
      cnt_q           <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            if (addr_err) begin
              // Rejected requests leave the memory-side registers untouched.
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (bus.req_write) begin
              state_q         <= WR;
              mem_address_q   <= word_idx;
              mem_writeData_q <= bus.req_wdata;
              mem_memWrite_q  <= 1'b1;
            end else begin
              state_q       <= RD;
              mem_address_q <= word_idx;
              mem_memRead_q <= 1'b1;
              cnt_q         <= CNT_INIT;
            end
          end
        end

        RD: begin
          if (cnt_q == 4'd0) begin
            // Sample while memRead is still high so idle bus data is never captured.
            resp_rdata_q  <= bus.mem_memData;
            mem_memRead_q <= 1'b0;
            state_q       <= RESP;
            resp_valid_q  <= 1'b1;
            resp_err_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        WR: begin
          mem_memWrite_q <= 1'b0;
          state_q        <= RESP;
          resp_valid_q   <= 1'b1;
          resp_err_q     <= 1'b0;
        end

        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          req_ready_q  <= 1'b1;
        end

        default: begin
          state_q        <= IDLE;
          req_ready_q    <= 1'b1;
          resp_valid_q   <= 1'b0;
          resp_err_q     <= 1'b0;
          mem_memRead_q  <= 1'b0;
          mem_memWrite_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_err      = resp_err_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writeData = mem_writeData_q;
  assign bus.mem_memRead   = mem_memRead_q;
  assign bus.mem_memWrite  = mem_memWrite_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench: two controllers (READ_WAIT 1 and 4) with behavioural memories and a reference model.
module tb_mem_access_ctrl;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_err = 0;

  logic        req_valid [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        req_ready [2];
  logic        resp_v    [2];
  logic        resp_err  [2];
  logic [31:0] resp_rdata[2];
  logic [31:0] m_addr    [2];
  logic [31:0] m_wdata   [2];
  logic        rd_s      [2];
  logic        wr_s      [2];

  logic [31:0] mem     [2][DEPTH];
  logic [31:0] ref_mem [2][DEPTH];
  logic [31:0] last_rd [2];

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_access_ctrl_if u_if ();
      mem_access_ctrl #(.DEPTH(DEPTH), .READ_WAIT(g == 0 ? 1 : 4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
      );
      assign u_if.req_valid = req_valid[g];
      assign u_if.req_write = req_write[g];
      assign u_if.req_addr  = req_addr[g];
      assign u_if.req_wdata = req_wdata[g];
      assign req_ready[g]   = u_if.req_ready;
      assign resp_v[g]      = u_if.resp_valid;
      assign resp_err[g]    = u_if.resp_err;
      assign resp_rdata[g]  = u_if.resp_rdata;
      assign m_addr[g]      = u_if.mem_address;
      assign m_wdata[g]     = u_if.mem_writeData;
      assign rd_s[g]        = u_if.mem_memRead;
      assign wr_s[g]        = u_if.mem_memWrite;
      assign u_if.mem_memData = (u_if.mem_memRead && u_if.mem_address < DEPTH)
                                ? mem[g][u_if.mem_address[7:0]] : 32'h003F_F00F;
      always @(posedge clk)
        if (u_if.mem_memWrite && u_if.mem_address < DEPTH)
          mem[g][u_if.mem_address[7:0]] = u_if.mem_writeData;
    end
  endgenerate

  typedef struct {
    int          dut;
    bit          err;
    logic [31:0] rdata;
    int          resp_cyc;
    int          rd_cyc;
    int          wr_cyc;
    logic [31:0] idx;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   acc_cyc;

  function automatic int rw(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present a request, wait for acceptance and push the model's expected response.
  task automatic issue(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit keep);
    exp_t e;
    int   lat;
    bit   ok;
    ok = 1'b0;
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    for (int i = 0; i < 64; i++) begin
      if (req_ready[d] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", {31'd0, req_ready[d]}, 32'd1);
      req_valid[d] = 1'b0;
      return;
    end
    e.dut   = d;
    e.idx   = addr >> 2;
    e.wdata = wdata;
    e.err   = (addr % 4 != 0) || ((addr / 4) >= DEPTH);
    if (e.err)   lat = 1;
    else if (wr) lat = 2;
    else         lat = rw(d) + 1;
    e.rd_cyc = (!e.err && !wr) ? rw(d) : 0;
    e.wr_cyc = (!e.err && wr) ? 1 : 0;
    if (!e.err && wr)  ref_mem[d][e.idx[7:0]] = wdata;
    if (!e.err && !wr) last_rd[d] = ref_mem[d][e.idx[7:0]];
    e.rdata    = last_rd[d];
    e.resp_cyc = cyc + lat;
    acc_cyc    = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    if (!keep) req_valid[d] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain_outstanding", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  int rd_cnt[2], wr_cnt[2], both_cnt[2];
  bit bad[2];

  always @(negedge clk) begin : monitor
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rd_s[d] === 1'b1 && wr_s[d] === 1'b1) both_cnt[d]++;
      if (rd_s[d] === 1'b1) rd_cnt[d]++;
      if (wr_s[d] === 1'b1) wr_cnt[d]++;
      if ((rd_s[d] === 1'b1 || wr_s[d] === 1'b1) && exp_q.size() > 0) begin
        if (m_addr[d] !== exp_q[0].idx) bad[d] = 1'b1;
        if (wr_s[d] === 1'b1 && m_wdata[d] !== exp_q[0].wdata) bad[d] = 1'b1;
      end
      if (resp_v[d] === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("resp_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("resp_dut", 32'(d), 32'(e.dut));
          check("resp_err", {31'd0, resp_err[d]}, {31'd0, e.err});
          check("resp_rdata", resp_rdata[d], e.rdata);
          check("resp_latency", 32'(cyc), 32'(e.resp_cyc));
          check("memRead_cycles", 32'(rd_cnt[d]), 32'(e.rd_cyc));
          check("memWrite_cycles", 32'(wr_cnt[d]), 32'(e.wr_cyc));
          check("strobe_overlap", 32'(both_cnt[d]), 32'd0);
          check("strobe_addr_data", {31'd0, bad[d]}, 32'd0);
        end
        rd_cnt[d] = 0; wr_cnt[d] = 0; both_cnt[d] = 0; bad[d] = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  initial begin : stim
    int a1;
    int r;
    logic [31:0] addr;
    logic [31:0] saved;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
      last_rd[d] = '0; rd_cnt[d] = 0; wr_cnt[d] = 0; both_cnt[d] = 0; bad[d] = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[d][i] = $urandom;
        ref_mem[d][i] = mem[d][i];
      end
    end
    mem[0][4] = 32'hDEAD_BEEF;
    ref_mem[0][4] = 32'hDEAD_BEEF;

    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", {31'd0, req_ready[d]}, 32'd1);
      check("rst_resp_valid", {31'd0, resp_v[d]}, 32'd0);
      check("rst_strobes", {30'd0, rd_s[d], wr_s[d]}, 32'd0);
      check("rst_rdata", resp_rdata[d], 32'd0);
      check("rst_mem_address", m_addr[d], 32'd0);
      check("rst_mem_wdata", m_wdata[d], 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Basic read, write then read-back at the top word.
    issue(0, 1'b0, 32'h10, 32'h0, 1'b0);
    drain();
    issue(0, 1'b1, 32'h3FC, 32'h1234_5678, 1'b0);
    drain();
    issue(0, 1'b0, 32'h3FC, 32'h0, 1'b0);
    drain();

    // Error paths must not disturb the memory-side registers.
    issue(0, 1'b0, 32'h6, 32'h0, 1'b0);
    drain();
    check("err_addr_hold", m_addr[0], 32'd255);
    issue(0, 1'b0, 32'h400, 32'h0, 1'b0);
    drain();
    issue(0, 1'b1, 32'h401, 32'hFFFF_FFFF, 1'b0);
    drain();
    check("err_addr_hold2", m_addr[0], 32'd255);
    check("err_wdata_hold", m_wdata[0], 32'h1234_5678);

    // Long read wait with the next request held pending.
    issue(1, 1'b0, 32'd7 << 2, 32'h0, 1'b1);
    a1 = acc_cyc;
    issue(1, 1'b0, 32'd8 << 2, 32'h0, 1'b0);
    check("rw4_accept_gap", 32'(acc_cyc - a1), 32'd6);
    drain();

    // Reset during the write cycle aborts the write.
    saved = ref_mem[0][9];
    issue(0, 1'b1, 32'd9 << 2, ~saved, 1'b0);
    #2;
    reset = 1'b1;
    exp_q.delete();
    for (int d = 0; d < 2; d++) begin
      rd_cnt[d] = 0; wr_cnt[d] = 0; both_cnt[d] = 0; bad[d] = 1'b0; last_rd[d] = '0;
    end
    ref_mem[0][9] = saved;
    #1;
    check("abort_memWrite_drop", {31'd0, wr_s[0]}, 32'd0);
    repeat (2) @(negedge clk);
    check("abort_no_resp", {31'd0, resp_v[0]}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_req_ready", {31'd0, req_ready[0]}, 32'd1);
    check("abort_no_resp_after", {31'd0, resp_v[0]}, 32'd0);
    issue(0, 1'b0, 32'd9 << 2, 32'h0, 1'b0);
    drain();

    // Back-to-back write then read with req_valid held.
    issue(0, 1'b1, 32'h20, 32'hA5A5_A5A5, 1'b1);
    a1 = acc_cyc;
    issue(0, 1'b0, 32'h20, 32'h0, 1'b0);
    check("b2b_accept_gap", 32'(acc_cyc - a1), 32'd3);
    drain();

    // Randomised traffic on both controllers.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      addr = ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
        else if (r == 1) addr = $urandom_range(256, 2000) << 2;
        else if (r < 6)  addr = $urandom_range(0, 15) << 2;
        else             addr = $urandom_range(0, 255) << 2;
        issue(d, 1'($urandom_range(0, 1)), addr, $urandom, 1'($urandom_range(0, 1)));
      end
      req_valid[d] = 1'b0;
      drain();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
